// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: decode-side issue/stall controller for the multiply/divide unit.
// Owns the D->E register for the MDU op and a shadow busy countdown that mirrors
// the MDU latency, holding any mult/div-class instruction in D while busy.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   d_valid, d_op   D-stage instruction valid and MDU op code (9-15 = none)
//   pipe_stall      stall from other hazard sources; freezes D
//   req             interrupt/exception request; squashes the E-stage op
//   stall_d         hold D for an MDU hazard (combinational)
//   e_op            registered op presented to the MDU in E
//   busy            start op in E or countdown non-zero (combinational)
//   count           shadow countdown
//   stall_cycles    saturating count of cycles with stall_d=1
module md_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned CNT_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [3:0]       d_op,
  input  logic             pipe_stall,
  input  logic             req,
  output logic             stall_d,
  output logic [3:0]       e_op,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      stall_cycles
);

  localparam int unsigned CNT_LIMIT = 2 ** CNT_W;

  if (MULT_LAT >= CNT_LIMIT || DIV_LAT >= CNT_LIMIT) begin : g_bad_lat
    $error("md_issue_ctrl: MULT_LAT/DIV_LAT must be below 2**CNT_W");
  end

  logic [3:0]       r_e_op;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_stall_cycles;

  logic             w_start;
  logic             w_is_mult;
  logic             w_md_class;
  logic             w_busy;
  logic             w_stall_d;
  logic [3:0]       w_d_op_ld;
  logic [CNT_W-1:0] w_lat;

  // Op classification: start ops occupy the MDU, md-class ops must wait for it.
  assign w_start    = (r_e_op >= 4'd1) && (r_e_op <= 4'd4);
  assign w_is_mult  = (r_e_op == 4'd1) || (r_e_op == 4'd2);
  assign w_md_class = (d_op >= 4'd1) && (d_op <= 4'd8);
  assign w_d_op_ld  = (d_op <= 4'd8) ? d_op : 4'd0;
  assign w_lat      = w_is_mult ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);

  assign w_busy     = w_start || (r_count != '0);
  assign w_stall_d  = d_valid && w_md_class && w_busy;

  // D->E op register, shadow countdown and stall performance counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e_op         <= 4'd0;
      r_count        <= '0;
      r_stall_cycles <= 32'd0;
    end else begin
      // A squashed or bubbled E slot is presented to the MDU as op 0.
      if (req || w_stall_d || pipe_stall || !d_valid) begin
        r_e_op <= 4'd0;
      end else begin
        r_e_op <= w_d_op_ld;
      end

      // A start cancelled by req never loads; a running count is committed.
      if (w_start && !req) begin
        r_count <= w_lat;
      end else if (r_count != '0) begin
        r_count <= r_count - CNT_W'(1);
      end

      if (w_stall_d && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign stall_d      = w_stall_d;
  assign busy         = w_busy;
  assign e_op         = r_e_op;
  assign count        = r_count;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: table-driven cycle vectors with a
// scoreboard queue, plus hand-written reset, mid-divide reset and saturation cases.
module tb_md_issue_ctrl;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [3:0]  d_op;
  logic        pipe_stall;
  logic        req;
  logic        stall_d;
  logic [3:0]  e_op;
  logic        busy;
  logic [3:0]  count;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_valid      (d_valid),
    .d_op         (d_op),
    .pipe_stall   (pipe_stall),
    .req          (req),
    .stall_d      (stall_d),
    .e_op         (e_op),
    .busy         (busy),
    .count        (count),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One record per cycle: inputs driven that cycle, outputs expected that cycle.
  typedef struct {
    logic       dv;
    logic [3:0] op;
    logic       ps;
    logic       rq;
    logic       ex_stall;
    logic [3:0] ex_eop;
    logic       ex_busy;
    logic [3:0] ex_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   seg_end[$];
  int   seg_stalls[$];

  task automatic add(input logic dv, input logic [3:0] op, input logic ps, input logic rq,
                     input logic es, input logic [3:0] ee, input logic eb, input logic [3:0] ec);
    vec_t v;
    v.dv = dv; v.op = op; v.ps = ps; v.rq = rq;
    v.ex_stall = es; v.ex_eop = ee; v.ex_busy = eb; v.ex_cnt = ec;
    vecs.push_back(v);
  endtask

  task automatic end_seg(input int stalls);
    seg_end.push_back(vecs.size());
    seg_stalls.push_back(stalls);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    d_valid = 1'b0; d_op = 4'd0; pipe_stall = 1'b0; req = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drive one vector, push its expectation, then sample away from the edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    d_valid = v.dv; d_op = v.op; pipe_stall = v.ps; req = v.rq;
    sb.push_back(v);
    #1;
    if (sb.size() == 0) begin
      chk($sformatf("v%0d_sb_empty", idx), 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("v%0d_stall_d", idx), 32'(stall_d), 32'(e.ex_stall));
      chk($sformatf("v%0d_e_op", idx),    32'(e_op),    32'(e.ex_eop));
      chk($sformatf("v%0d_busy", idx),    32'(busy),    32'(e.ex_busy));
      chk($sformatf("v%0d_count", idx),   32'(count),   32'(e.ex_cnt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int start;
    reset = 1'b1; d_valid = 1'b0; d_op = 4'd0; pipe_stall = 1'b0; req = 1'b0;

    // Seg 0: mult then dependent mflo; mflo enters E at t+7, six stall cycles.
    add(1, 4'd1, 0, 0,  0, 4'd0, 0, 4'd0);
    add(1, 4'd6, 0, 0,  1, 4'd1, 1, 4'd0);
    for (int c = 5; c >= 1; c--) add(1, 4'd6, 0, 0, 1, 4'd0, 1, 4'(c));
    add(1, 4'd6, 0, 0,  0, 4'd0, 0, 4'd0);
    add(0, 4'd0, 0, 0,  0, 4'd6, 0, 4'd0);
    end_seg(6);

    // Seg 1: div then mthi; released at t+11, eleven stall cycles.
    add(1, 4'd3, 0, 0,  0, 4'd0, 0, 4'd0);
    add(1, 4'd7, 0, 0,  1, 4'd3, 1, 4'd0);
    for (int c = 10; c >= 1; c--) add(1, 4'd7, 0, 0, 1, 4'd0, 1, 4'(c));
    add(1, 4'd7, 0, 0,  0, 4'd0, 0, 4'd0);
    add(0, 4'd0, 0, 0,  0, 4'd7, 0, 4'd0);
    end_seg(11);

    // Seg 2: req while mult in E squashes it; following mfhi flows freely.
    add(1, 4'd1, 0, 0,  0, 4'd0, 0, 4'd0);
    add(1, 4'd5, 0, 1,  1, 4'd1, 1, 4'd0);
    add(1, 4'd5, 0, 0,  0, 4'd0, 0, 4'd0);
    add(0, 4'd0, 0, 0,  0, 4'd5, 0, 4'd0);
    add(0, 4'd0, 0, 0,  0, 4'd0, 0, 4'd0);
    end_seg(1);

    // Seg 3: req at count=3 during div does not abort the countdown.
    add(1, 4'd3, 0, 0,  0, 4'd0, 0, 4'd0);
    add(1, 4'd6, 0, 0,  1, 4'd3, 1, 4'd0);
    for (int c = 10; c >= 4; c--) add(1, 4'd6, 0, 0, 1, 4'd0, 1, 4'(c));
    add(1, 4'd6, 0, 1,  1, 4'd0, 1, 4'd3);
    add(1, 4'd6, 0, 0,  1, 4'd0, 1, 4'd2);
    add(1, 4'd6, 0, 0,  1, 4'd0, 1, 4'd1);
    add(1, 4'd6, 0, 0,  0, 4'd0, 0, 4'd0);
    add(0, 4'd0, 0, 0,  0, 4'd6, 0, 4'd0);
    end_seg(11);

    // Seg 4: pipe_stall bubbles without counting; non-MD and codes 9-15 never stall.
    add(1, 4'd1, 1, 0,  0, 4'd0, 0, 4'd0);
    add(1, 4'd1, 0, 0,  0, 4'd0, 0, 4'd0);
    add(1, 4'd0, 1, 0,  0, 4'd1, 1, 4'd0);
    add(0, 4'd0, 0, 0,  0, 4'd0, 1, 4'd5);
    add(1, 4'd12, 0, 0, 0, 4'd0, 1, 4'd4);
    add(0, 4'd0, 0, 0,  0, 4'd0, 1, 4'd3);
    add(1, 4'd1, 0, 0,  1, 4'd0, 1, 4'd2);
    end_seg(1);

    // Reset then idle for 10 cycles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    chk("idle_e_op", 32'(e_op), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_stall_d", 32'(stall_d), 32'd0);
    chk("idle_stall_cycles", stall_cycles, 32'd0);

    start = 0;
    for (int s = 0; s < seg_end.size(); s++) begin
      do_reset();
      for (int i = start; i < seg_end[s]; i++) step(vecs[i], i);
      chk($sformatf("seg%0d_stall_cycles", s), stall_cycles, 32'(seg_stalls[s]));
      start = seg_end[s];
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Reset asserted mid-divide clears the countdown at that edge.
    do_reset();
    d_valid = 1'b1; d_op = 4'd3;
    @(posedge clk); #1;
    d_valid = 1'b0; d_op = 4'd0;
    @(posedge clk); #1;
    chk("middiv_count_loaded", 32'(count), 32'd10);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("middiv_count_cleared", 32'(count), 32'd0);
    chk("middiv_busy_cleared", 32'(busy), 32'd0);
    reset = 1'b0;

    // Saturation: preload near the top, then hold a stall for 3 cycles.
    do_reset();
    d_valid = 1'b1; d_op = 4'd1;
    @(posedge clk); #1;
    force dut.r_stall_cycles = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cycles;
    d_op = 4'd6;
    #1;
    chk("sat_stall_d", 32'(stall_d), 32'd1);
    chk("sat_preload", stall_cycles, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    chk("sat_first", stall_cycles, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    chk("sat_still_stalled", 32'(stall_d), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
- Issue and stall controller on the decode side of the multiply/divide unit; it is the requester end of the MDU handshake.
- Owns the D→E register for the MDU operation and keeps a shadow busy countdown that tracks the MDU latency.
- Holds any multiply/divide-class instruction in D while the MDU is starting or still counting.
- Kills the E-stage operation on an interrupt/exception request and counts stall cycles for the performance counters.

Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu leaves E.
- DIV_LAT, 10, busy cycles after a div/divu leaves E.
- CNT_W, 4, countdown width; elaboration error if DIV_LAT or MULT_LAT >= 2^CNT_W.

Ports:
- clk  input  1  clock
- reset  input  1  reset
- d_valid  input  1  D-stage instruction valid
- d_op  input  4  D-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none
- pipe_stall  input  1  stall from other hazard sources; freezes D
- req  input  1  interrupt/exception request; squashes the E-stage op
- stall_d  output  1  hold D for an MDU hazard
- e_op  output  4  registered op presented to the MDU in E
- busy  output  1  e_op is a start op, or count != 0
- count  output  CNT_W  shadow countdown
- stall_cycles  output  32  saturating count of cycles with stall_d=1

Behaviour:
- Reset:
  - Synchronous, active-high, clocked on clk.
  - e_op=0, count=0, stall_cycles=0; therefore busy=0 and stall_d=0.
  - Reset asserted mid-divide clears count immediately at that edge.
- Classes:
  - start = e_op in {1,2,3,4}.
  - md_class(d_op) = d_op in 1..8.
- stall_d (combinational) = d_valid & md_class(d_op) & busy.
  - Any MD-class op waits, including mthi/mtlo and back-to-back mult.
  - Non-MD ops never stall here.
- busy (combinational) = start | (count != 0).
- e_op register, each posedge in priority order:
  - req=1 → 0.
  - Else stall_d | pipe_stall → 0 (bubble into E).
  - Else d_valid → d_op (codes 9-15 are loaded as 0).
  - Else → 0.
- Countdown, each posedge in priority order:
  - start & ~req → count = MULT_LAT for codes 1/2, DIV_LAT for codes 3/4.
  - Else count != 0 → count-1.
  - Else hold 0.
  - req does not abort a count already running; the operation is committed.
- Squashed start: a start op in E during a req cycle loads no count, and the MDU must see it as cancelled.
- Timing:
  - A mult in E at cycle t gives count=5 at t+1, down to count=0 at t+6.
  - A dependent mflo held in D is released at t+6 and enters E at t+7.
  - For div the release is at t+11.
- mf/mt ops in E do not affect count or busy.
- Simultaneous events: a start in E with another start in D gives stall_d=1 that cycle; the D op waits for the full latency.
- stall_cycles: +1 on every posedge where stall_d=1 and reset=0; saturates at 0xFFFFFFFF with no wrap.
- pipe_stall alone does not increment stall_cycles.

Test Plan:
- Reset then idle: d_valid=0 for 10 cycles → e_op=0, busy=0, count=0, stall_cycles=0.
- mult followed by mflo: mult enters E at t → count=5 at t+1, stall_d=1 for t..t+5, mflo enters E at t+7, stall_cycles=6.
- div followed by mthi with the same shape → count=10 at t+1, mthi released at t+11, stall_cycles=11.
- req while a mult is in E → count stays 0, e_op=0 next cycle; a following mfhi is not stalled after the req cycle.
- req at count=3 during a div → count continues 2,1,0; a pending mflo is released on schedule.
- Saturation: force stall_cycles to 0xFFFFFFFE, then hold a stall for 3 cycles → counter reads 0xFFFFFFFF.
- Non-MD op in D during busy: d_op=0, d_valid=1 → stall_d=0.
